// File: rtl/lvl_state_table.sv
// Decision-level state table with a backward search for the highest level
// that still has an untried branch, plus backtrack commit.
module lvl_state_table #(
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 dcd_valid_i,
  input  logic [WIDTH_LVL-1:0]                 cur_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]              cur_bin_num_i,
  input  logic                                 find_start_i,
  input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
  output logic                                 busy_o,
  output logic                                 find_done_o,
  output logic                                 find_found_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o,
  input  logic                                 apply_bkt_i,
  input  logic [NUM_LVLS-1:0]                  wr_states_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int                   W       = WIDTH_LVL_STATES;
  localparam logic [WIDTH_LVL-1:0] MAX_IDX = WIDTH_LVL'(NUM_LVLS - 1);

  state_t                  r_state;
  logic [WIDTH_LVL-1:0]    r_idx;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_found;
  logic [WIDTH_LVL-1:0]    r_bkt_lvl;
  logic [WIDTH_BIN_ID-1:0] r_bkt_bin;

  logic [W*NUM_LVLS-1:0]   w_table;
  logic [W-1:0]            w_cur_entry;
  logic                    w_apply;

  assign w_apply = (r_state == IDLE) && apply_bkt_i && r_found;

  // Entry under the search pointer, read from the live table.
  always_comb begin
    w_cur_entry = '0;
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (r_idx == WIDTH_LVL'(i)) w_cur_entry = w_table[i*W +: W];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LVLS; gi++) begin : g_entry
      localparam logic [WIDTH_LVL-1:0] IDX = WIDTH_LVL'(gi);
      logic [W-1:0] r_entry;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry <= '0;
        end else if (w_apply && (r_bkt_lvl == IDX)) begin
          r_entry <= r_entry | W'(1);
        end else if (w_apply && (r_bkt_lvl < IDX)) begin
          r_entry <= '0;
        end else if (wr_states_i[gi]) begin
          r_entry <= lvl_states_i[gi*W +: W];
        end else if (dcd_valid_i && (cur_lvl_i == IDX)) begin
          r_entry <= W'({cur_bin_num_i, 1'b0});
        end
      end

      assign w_table[gi*W +: W] = r_entry;
    end
  endgenerate

  assign lvl_states_o = w_table;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_found   <= 1'b0;
      r_bkt_lvl <= '0;
      r_bkt_bin <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A backtrack request in the same cycle always swallows a start.
          if (apply_bkt_i) begin
            if (r_found) r_found <= 1'b0;
          end else if (find_start_i) begin
            r_idx   <= (max_lvl_i > MAX_IDX) ? MAX_IDX : max_lvl_i;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if ((r_idx != '0) && !w_cur_entry[0]) begin
            r_bkt_lvl <= r_idx;
            r_bkt_bin <= w_cur_entry[WIDTH_BIN_ID:1];
            r_found   <= 1'b1;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end else if (r_idx == '0) begin
            r_bkt_lvl <= '0;
            r_bkt_bin <= '0;
            r_found   <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign find_done_o  = r_done;
  assign find_found_o = r_found;
  assign bkt_lvl_o    = r_bkt_lvl;
  assign bkt_bin_o    = r_bkt_bin;

endmodule

// File: tb/tb_lvl_state_table.sv
// Directed bench for lvl_state_table: table model plus a scoreboard queue of
// expected search results (latency, found, level, bin).
module tb_lvl_state_table;

  localparam int N  = 8;
  localparam int WL = 16;
  localparam int WB = 10;
  localparam int W  = WB + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            dcd_valid_i;
  logic [WL-1:0]   cur_lvl_i;
  logic [WB-1:0]   cur_bin_num_i;
  logic            find_start_i;
  logic [WL-1:0]   max_lvl_i;
  logic            busy_o;
  logic            find_done_o;
  logic            find_found_o;
  logic [WL-1:0]   bkt_lvl_o;
  logic [WB-1:0]   bkt_bin_o;
  logic            apply_bkt_i;
  logic [N-1:0]    wr_states_i;
  logic [W*N-1:0]  lvl_states_i;
  logic [W*N-1:0]  lvl_states_o;

  lvl_state_table #(
    .NUM_LVLS(N), .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_LVL_STATES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .dcd_valid_i(dcd_valid_i), .cur_lvl_i(cur_lvl_i), .cur_bin_num_i(cur_bin_num_i),
    .find_start_i(find_start_i), .max_lvl_i(max_lvl_i),
    .busy_o(busy_o), .find_done_o(find_done_o), .find_found_o(find_found_o),
    .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
    .apply_bkt_i(apply_bkt_i), .wr_states_i(wr_states_i),
    .lvl_states_i(lvl_states_i), .lvl_states_o(lvl_states_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lat;
    logic          found;
    logic [WL-1:0] lvl;
    logic [WB-1:0] bin;
  } exp_t;

  exp_t       sb[$];
  logic [W-1:0] m_tab [N];
  int         checks = 0;
  int         errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ent(input int bin, input logic hb);
    return {WB'(bin), hb};
  endfunction

  function automatic logic [W*N-1:0] pack_model();
    logic [W*N-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = m_tab[i];
    return p;
  endfunction

  task automatic check_table(input string tag);
    check(tag, 128'(lvl_states_o), 128'(pack_model()));
  endtask

  task automatic decide(input int lvl, input int bin);
    dcd_valid_i = 1'b1;
    cur_lvl_i = WL'(lvl);
    cur_bin_num_i = WB'(bin);
    step();
    dcd_valid_i = 1'b0;
    if (lvl < N) m_tab[lvl] = ent(bin, 1'b0);
    $display("decide lvl=%0d bin=%0d", lvl, bin);
  endtask

  // Unmasked slices carry inverted data so a stray write shows up.
  task automatic load(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      lvl_states_i[i*W +: W] = mask[i] ? m_tab[i] : ~m_tab[i];
    wr_states_i = mask;
    step();
    wr_states_i = '0;
    $display("load mask=%02h", mask);
  endtask

  task automatic run_find(input logic [WL-1:0] max, input logic ef, input logic [WL-1:0] el,
                          input logic [WB-1:0] eb, input int elat, input int pulse_at);
    exp_t e;
    int   n;
    sb.push_back('{elat, ef, el, eb});
    max_lvl_i = max;
    find_start_i = 1'b1;
    step();
    find_start_i = 1'b0;
    n = 1;
    check("busy_scan", 128'(busy_o), 128'(1));
    while (find_done_o !== 1'b1 && n < 40) begin
      if (n == pulse_at) find_start_i = 1'b1;
      step();
      find_start_i = 1'b0;
      n++;
    end
    e = sb.pop_front();
    check("done_latency", 128'(n), 128'(e.lat));
    check("found", 128'(find_found_o), 128'(e.found));
    check("bkt_lvl", 128'(bkt_lvl_o), 128'(e.lvl));
    check("bkt_bin", 128'(bkt_bin_o), 128'(e.bin));
    check("busy_at_done", 128'(busy_o), 128'(0));
    $display("find max=%0d lat=%0d found=%0b lvl=%0d bin=%0d", max, n, find_found_o, bkt_lvl_o, bkt_bin_o);
    step();
    check("done_one_cycle", 128'(find_done_o), 128'(0));
    check("busy_after_done", 128'(busy_o), 128'(0));
  endtask

  initial begin
    rst = 1'b1;
    dcd_valid_i = 1'b0;
    cur_lvl_i = '0;
    cur_bin_num_i = '0;
    find_start_i = 1'b0;
    max_lvl_i = '0;
    apply_bkt_i = 1'b0;
    wr_states_i = '0;
    lvl_states_i = '0;
    for (int i = 0; i < N; i++) m_tab[i] = '0;
    step(); step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_done", 128'(find_done_o), 128'(0));
    check("rst_found", 128'(find_found_o), 128'(0));
    check("rst_lvl", 128'(bkt_lvl_o), 128'(0));
    check("rst_bin", 128'(bkt_bin_o), 128'(0));
    check_table("rst_table");

    // Decisions on levels 1..5; out-of-range levels are dropped
    for (int l = 1; l <= 5; l++) decide(l, 10 + l);
    decide(8, 99);
    decide(9, 98);
    check_table("decide_table");

    run_find(16'd5, 1'b1, 16'd5, 10'd15, 2, 0);

    // has_bkt on 4 and 5 pushes the result down to level 3
    m_tab[4] = ent(14, 1'b1);
    m_tab[5] = ent(15, 1'b1);
    load(8'b0011_0000);
    check_table("load_table");
    run_find(16'd5, 1'b1, 16'd3, 10'd13, 4, 0);

    // Result holds while idle
    step(); step(); step();
    check("hold_found", 128'(find_found_o), 128'(1));
    check("hold_lvl", 128'(bkt_lvl_o), 128'(3));
    check("hold_bin", 128'(bkt_bin_o), 128'(13));

    apply_bkt_i = 1'b1;
    step();
    apply_bkt_i = 1'b0;
    m_tab[3] = ent(13, 1'b1);
    for (int i = 4; i < N; i++) m_tab[i] = '0;
    check_table("apply_table");
    check("apply_found_clr", 128'(find_found_o), 128'(0));
    $display("apply lvl=3");

    // Apply with found=0 is ignored
    apply_bkt_i = 1'b1;
    step();
    apply_bkt_i = 1'b0;
    check_table("apply_ignored_table");

    // All decided levels tried -> not found
    for (int i = 1; i <= 5; i++) m_tab[i] = ent(10 + i, 1'b1);
    load(8'b0011_1110);
    run_find(16'd5, 1'b0, 16'd0, 10'd0, 7, 0);

    // Clamp of max_lvl, start pulses during SCAN ignored
    for (int i = 0; i < N; i++) m_tab[i] = ent(20 + i, 1'b0);
    load(8'hFF);
    run_find(16'd20, 1'b1, 16'd7, 10'd27, 2, 1);
    m_tab[6] = ent(26, 1'b1);
    m_tab[7] = ent(27, 1'b1);
    load(8'b1100_0000);
    run_find(16'd7, 1'b1, 16'd5, 10'd25, 4, 2);
    check("no_restart_busy", 128'(busy_o), 128'(0));

    // Level 0 is never reported
    run_find(16'd0, 1'b0, 16'd0, 10'd0, 2, 0);

    // Write priority: apply > load > decide, and apply swallows a start
    run_find(16'd3, 1'b1, 16'd3, 10'd23, 2, 0);
    apply_bkt_i = 1'b1;
    find_start_i = 1'b1;
    max_lvl_i = 16'd7;
    lvl_states_i = '0;
    lvl_states_i[1*W +: W] = ent(77, 1'b0);
    lvl_states_i[5*W +: W] = ent(55, 1'b1);
    wr_states_i = 8'b0010_0010;
    dcd_valid_i = 1'b1;
    cur_lvl_i = 16'd6;
    cur_bin_num_i = 10'd66;
    step();
    apply_bkt_i = 1'b0;
    find_start_i = 1'b0;
    wr_states_i = '0;
    dcd_valid_i = 1'b0;
    m_tab[1] = ent(77, 1'b0);
    m_tab[3] = ent(23, 1'b1);
    for (int i = 4; i < N; i++) m_tab[i] = '0;
    check_table("prio_apply_table");
    check("prio_start_dropped", 128'(busy_o), 128'(0));
    check("prio_found_clr", 128'(find_found_o), 128'(0));
    step();
    check("prio_no_done", 128'(find_done_o), 128'(0));
    $display("priority apply+load+decide+start");

    lvl_states_i[2*W +: W] = ent(88, 1'b1);
    wr_states_i = 8'b0000_0100;
    dcd_valid_i = 1'b1;
    cur_lvl_i = 16'd2;
    cur_bin_num_i = 10'd99;
    step();
    wr_states_i = '0;
    dcd_valid_i = 1'b0;
    m_tab[2] = ent(88, 1'b1);
    check_table("prio_load_over_decide");
    $display("priority load+decide");

    // Reset in the middle of a search
    for (int i = 0; i < N; i++) m_tab[i] = ent(30 + i, 1'b1);
    load(8'hFF);
    max_lvl_i = 16'd5;
    find_start_i = 1'b1;
    step();
    find_start_i = 1'b0;
    step();
    check("pre_rst_busy", 128'(busy_o), 128'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) m_tab[i] = '0;
    check("mid_rst_busy", 128'(busy_o), 128'(0));
    check("mid_rst_found", 128'(find_found_o), 128'(0));
    check("mid_rst_lvl", 128'(bkt_lvl_o), 128'(0));
    check("mid_rst_bin", 128'(bkt_bin_o), 128'(0));
    check_table("mid_rst_table");
    for (int k = 0; k < 10; k++) begin
      check("mid_rst_no_done", 128'(find_done_o), 128'(0));
      step();
    end
    $display("reset during search");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
